// File: rtl/fpx_pkg.sv
// Shared types and width helpers for the minifloat multiplier array.
// Format is sign|exp|man with an implicit leading one and no subnormals.
package fpx_pkg;

  typedef enum logic {
    RND_RTZ = 1'b0,
    RND_RNE = 1'b1
  } rnd_mode_e;

  // Per-lane exception flags travelling alongside each result.
  typedef struct packed {
    logic of;
    logic uf;
  } fpx_flags_t;

  function automatic int unsigned fpx_width(input int unsigned exp_w, input int unsigned man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int unsigned fpx_emax(input int unsigned exp_w);
    return (1 << exp_w) - 1;
  endfunction

  function automatic int unsigned fpx_prod_w(input int unsigned man_w);
    return 2 * man_w + 2;
  endfunction

endpackage

// File: rtl/fpx_mul_lane.sv
// Combinational single-lane minifloat multiplier with truncate or round-to-nearest-even,
// saturating on overflow and flushing to zero on underflow.
module fpx_mul_lane
  import fpx_pkg::*;
#(
  parameter int unsigned EXP_W = 2,
  parameter int unsigned MAN_W = 1,
  parameter int unsigned BIAS  = 1,
  localparam int unsigned W    = fpx_width(EXP_W, MAN_W)
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  rnd_mode_e    rnd,
  output logic [W-1:0] result,
  output logic         of,
  output logic         uf
);

  localparam int unsigned PW   = fpx_prod_w(MAN_W);
  localparam int unsigned FW   = 2 * MAN_W + 1;
  localparam int unsigned EW   = EXP_W + 2;
  localparam int unsigned EMAX = fpx_emax(EXP_W);

  logic             sign;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic             zero;

  assign sign = a[W-1] ^ b[W-1];
  assign ea   = a[W-2:MAN_W];
  assign eb   = b[W-2:MAN_W];
  assign ma   = a[MAN_W-1:0];
  assign mb   = b[MAN_W-1:0];
  assign zero = (ea == '0 && ma == '0) || (eb == '0 && mb == '0);

  logic [PW-1:0] prod;
  logic          norm;
  logic [FW-1:0] frac;
  logic [MAN_W-1:0] m_keep;
  logic          rbit, sticky;

  assign prod   = PW'({1'b1, ma}) * PW'({1'b1, mb});
  assign norm   = prod[PW-1];
  // Left-align the fraction so the kept/round/sticky split is the same for both cases.
  assign frac   = norm ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
  assign m_keep = frac[FW-1 -: MAN_W];
  assign rbit   = frac[MAN_W];
  assign sticky = |frac[MAN_W-1:0];

  logic signed [EW-1:0] e_norm;
  assign e_norm = $signed({2'b00, ea}) + $signed({2'b00, eb}) - $signed(EW'(BIAS))
                + $signed({{(EW-1){1'b0}}, norm});

  logic             round_up;
  logic [MAN_W:0]   m_inc;
  logic [MAN_W-1:0] m_fin;
  logic signed [EW-1:0] e_fin;

  always_comb begin
    round_up = (rnd == RND_RNE) && rbit && (sticky || m_keep[0]);
    m_inc    = {1'b0, m_keep} + {{MAN_W{1'b0}}, 1'b1};
    m_fin    = round_up ? m_inc[MAN_W-1:0] : m_keep;
    e_fin    = e_norm + $signed({{(EW-1){1'b0}}, round_up & m_inc[MAN_W]});
  end

  always_comb begin
    result = {sign, e_fin[EXP_W-1:0], m_fin};
    of     = 1'b0;
    uf     = 1'b0;
    if (zero) begin
      result = {sign, {(W-1){1'b0}}};
    end else if (e_fin > $signed(EW'(EMAX))) begin
      result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
      of     = 1'b1;
    end else if (e_fin[EW-1] || (e_fin == '0 && m_fin == '0)) begin
      result = {sign, {(W-1){1'b0}}};
      uf     = 1'b1;
    end
  end

endmodule

// File: rtl/fpx_mul_array.sv
// LANES minifloat multipliers behind a shared valid/ready pipeline of PIPE_STAGES registers.
// Results and flags are computed ahead of the first register and carried with their data.
module fpx_mul_array
  import fpx_pkg::*;
#(
  parameter int unsigned EXP_W       = 2,
  parameter int unsigned MAN_W       = 1,
  parameter int unsigned BIAS        = 1,
  parameter int unsigned LANES       = 4,
  parameter int unsigned PIPE_STAGES = 2,
  localparam int unsigned W          = fpx_width(EXP_W, MAN_W)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_rnd_mode,
  input  logic [LANES*W-1:0] i_a,
  input  logic [LANES*W-1:0] i_b,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [LANES*W-1:0] o_result,
  output logic [LANES-1:0]   o_of,
  output logic [LANES-1:0]   o_uf
);

  localparam int unsigned LAST = PIPE_STAGES - 1;

  typedef struct packed {
    logic [LANES*W-1:0] result;
    logic [LANES-1:0]   of;
    logic [LANES-1:0]   uf;
  } stage_t;

  logic [LANES*W-1:0] lane_res;
  fpx_flags_t         lane_flags [LANES];
  stage_t             lane_out;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    fpx_mul_lane #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W),
      .BIAS  (BIAS)
    ) u_lane (
      .a      (i_a[k*W +: W]),
      .b      (i_b[k*W +: W]),
      .rnd    (rnd_mode_e'(i_rnd_mode)),
      .result (lane_res[k*W +: W]),
      .of     (lane_flags[k].of),
      .uf     (lane_flags[k].uf)
    );
  end

  always_comb begin
    lane_out        = '0;
    lane_out.result = lane_res;
    for (int k = 0; k < LANES; k++) begin
      lane_out.of[k] = lane_flags[k].of;
      lane_out.uf[k] = lane_flags[k].uf;
    end
  end

  stage_t                 stage_q [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] valid_q;
  logic [PIPE_STAGES-1:0] load;
  logic                   in_fire;

  // A stage may load when empty or when the stage after it is taking its contents.
  always_comb begin
    load       = '0;
    load[LAST] = !valid_q[LAST] || i_ready;
    for (int s = int'(PIPE_STAGES) - 2; s >= 0; s--) begin
      load[s] = !valid_q[s] || load[s+1];
    end
  end

  assign o_ready = load[0] && !i_rst;
  assign in_fire = i_valid && o_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        stage_q[s] <= '0;
      end
    end else begin
      if (load[0]) begin
        valid_q[0] <= in_fire;
        if (in_fire) begin
          stage_q[0] <= lane_out;
        end
      end
      for (int s = 1; s < PIPE_STAGES; s++) begin
        if (load[s]) begin
          valid_q[s] <= valid_q[s-1];
          if (valid_q[s-1]) begin
            stage_q[s] <= stage_q[s-1];
          end
        end
      end
    end
  end

  assign o_valid  = valid_q[LAST];
  assign o_result = stage_q[LAST].result;
  assign o_of     = stage_q[LAST].of;
  assign o_uf     = stage_q[LAST].uf;

endmodule

// File: tb/tb_fpx_mul_array.sv
// Scoreboard bench: default 4-lane array plus a wider-format single-lane, 3-stage instance.
module tb_fpx_mul_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Default configuration: EXP_W=2 MAN_W=1 BIAS=1 LANES=4 PIPE_STAGES=2
  logic        a_valid, a_oready, a_rnd, a_ovalid, a_iready;
  logic [15:0] a_a, a_b, a_res;
  logic [3:0]  a_of, a_uf;

  // Wider format: EXP_W=3 MAN_W=2 BIAS=3 LANES=1 PIPE_STAGES=3
  logic        b_valid, b_oready, b_rnd, b_ovalid, b_iready;
  logic [5:0]  b_a, b_b, b_res;
  logic [0:0]  b_of, b_uf;

  fpx_mul_array dut_a (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (a_valid),
    .o_ready    (a_oready),
    .i_rnd_mode (a_rnd),
    .i_a        (a_a),
    .i_b        (a_b),
    .o_valid    (a_ovalid),
    .i_ready    (a_iready),
    .o_result   (a_res),
    .o_of       (a_of),
    .o_uf       (a_uf)
  );

  fpx_mul_array #(
    .EXP_W       (3),
    .MAN_W       (2),
    .BIAS        (3),
    .LANES       (1),
    .PIPE_STAGES (3)
  ) dut_b (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (b_valid),
    .o_ready    (b_oready),
    .i_rnd_mode (b_rnd),
    .i_a        (b_a),
    .i_b        (b_b),
    .o_valid    (b_ovalid),
    .i_ready    (b_iready),
    .o_result   (b_res),
    .o_of       (b_of),
    .o_uf       (b_uf)
  );

  typedef struct {
    logic [15:0] res;
    logic [3:0]  of;
    logic [3:0]  uf;
    int          t;
    bit          lat;
  } exp_a_t;

  typedef struct {
    logic [5:0] res;
    logic       of;
    logic       uf;
    int         t;
    bit         lat;
  } exp_b_t;

  exp_a_t q_a[$];
  exp_b_t q_b[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_out_a = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Hand-computed default-format vectors; lane k sits in nibble k.
  logic [15:0] va_a [8] = '{16'h0003, 16'h0523, 16'h1191, 16'hE666,
                            16'h0001, 16'h0008, 16'h2222, 16'h3B00};
  logic [15:0] va_b [8] = '{16'h0003, 16'hE5B3, 16'h1111, 16'h6632,
                            16'h0002, 16'h0001, 16'h2222, 16'h33BB};
  logic [15:0] va_r [8] = '{16'h0004, 16'h87B4, 16'h0080, 16'hF776,
                            16'h0001, 16'h0008, 16'h2222, 16'h4C88};
  logic [3:0]  va_of [8] = '{4'h0, 4'h4, 4'h0, 4'hC, 4'h0, 4'h0, 4'h0, 4'h0};
  logic [3:0]  va_uf [8] = '{4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

  // Wider format vectors: RTZ/RNE tie with carry, sign, tie-to-even, underflow, overflow, zero.
  logic [5:0] vb_a [8]   = '{6'h0D, 6'h0D, 6'h2D, 6'h0A, 6'h01, 6'h3F, 6'h0D, 6'h00};
  logic [5:0] vb_b [8]   = '{6'h0E, 6'h0E, 6'h0E, 6'h0A, 6'h01, 6'h1F, 6'h0D, 6'h3F};
  logic       vb_rnd [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [5:0] vb_r [8]   = '{6'h0F, 6'h10, 6'h30, 6'h08, 6'h00, 6'h3F, 6'h0E, 6'h20};
  logic       vb_of [8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic       vb_uf [8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Monitor for the default instance, including hold-stability while stalled.
  initial begin
    logic [15:0] held_res;
    logic [3:0]  held_of, held_uf;
    bit          held_v;
    int          idx;
    exp_a_t      e;
    held_v = 0;
    idx    = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 0;
      end else begin
        if (a_ovalid && !a_iready) begin
          if (held_v) begin
            chk("a_hold_result", a_res, held_res);
            chk("a_hold_of", a_of, held_of);
            chk("a_hold_uf", a_uf, held_uf);
          end
          held_v   = 1;
          held_res = a_res;
          held_of  = a_of;
          held_uf  = a_uf;
        end else begin
          held_v = 0;
        end
        if (a_ovalid && a_iready) begin
          n_out_a++;
          if (q_a.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL a_unexpected: got result 0x%0h, expected no output", a_res);
          end else begin
            e = q_a.pop_front();
            chk($sformatf("a_result[%0d]", idx), a_res, e.res);
            chk($sformatf("a_of[%0d]", idx), a_of, e.of);
            chk($sformatf("a_uf[%0d]", idx), a_uf, e.uf);
            if (e.lat) chk("a_latency", cyc - e.t, 2);
            idx++;
          end
        end
      end
    end
  end

  initial begin
    int     idx;
    exp_b_t e;
    idx = 0;
    forever begin
      @(negedge clk);
      if (!rst && b_ovalid && b_iready) begin
        if (q_b.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL b_unexpected: got result 0x%0h, expected no output", b_res);
        end else begin
          e = q_b.pop_front();
          chk($sformatf("b_result[%0d]", idx), b_res, e.res);
          chk($sformatf("b_of[%0d]", idx), b_of, e.of);
          chk($sformatf("b_uf[%0d]", idx), b_uf, e.uf);
          if (e.lat) chk("b_latency", cyc - e.t, 3);
          idx++;
        end
      end
    end
  end

  task automatic send_a(input int i, input logic rnd, input bit lat);
    int     w;
    exp_a_t e;
    w       = 0;
    a_valid = 1'b1;
    a_a     = va_a[i];
    a_b     = va_b[i];
    a_rnd   = rnd;
    @(negedge clk);
    while (!a_oready && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (!a_oready) begin
      bound_fail("a_accept");
    end else begin
      e.res = va_r[i];
      e.of  = va_of[i];
      e.uf  = va_uf[i];
      e.t   = cyc;
      e.lat = lat;
      q_a.push_back(e);
    end
    @(posedge clk);
    #1;
    a_valid = 1'b0;
  endtask

  task automatic send_b(input int i, input bit lat);
    int     w;
    exp_b_t e;
    w       = 0;
    b_valid = 1'b1;
    b_a     = vb_a[i];
    b_b     = vb_b[i];
    b_rnd   = vb_rnd[i];
    @(negedge clk);
    while (!b_oready && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (!b_oready) begin
      bound_fail("b_accept");
    end else begin
      e.res = vb_r[i];
      e.of  = vb_of[i];
      e.uf  = vb_uf[i];
      e.t   = cyc;
      e.lat = lat;
      q_b.push_back(e);
    end
    @(posedge clk);
    #1;
    b_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((q_a.size() > 0 || q_b.size() > 0) && w < 100) begin
      w++;
      @(negedge clk);
    end
    if (q_a.size() > 0 || q_b.size() > 0) bound_fail("drain");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    rst      = 1'b1;
    a_valid  = 1'b0;
    a_rnd    = 1'b0;
    a_a      = '0;
    a_b      = '0;
    a_iready = 1'b1;
    b_valid  = 1'b0;
    b_rnd    = 1'b0;
    b_a      = '0;
    b_b      = '0;
    b_iready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_valid", a_ovalid, 0);
    chk("rst_o_ready", a_oready, 0);
    chk("rst_o_result", a_res, 0);
    chk("rst_o_of", a_of, 0);
    chk("rst_o_uf", a_uf, 0);
    chk("rst_b_o_valid", b_ovalid, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_o_ready", a_oready, 1);
    @(posedge clk);
    #1;

    // Single set, unstalled, with latency measured.
    send_a(0, 1'b0, 1'b1);
    wait_drain();

    // Eight back-to-back sets with downstream stalled for cycles 3..5.
    fork
      begin
        for (int i = 0; i < 8; i++) send_a(i, 1'(i % 2), 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        a_iready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("stall_o_ready_low", a_oready, 0);
        @(posedge clk);
        #1;
        a_iready = 1'b1;
      end
    join
    wait_drain();

    // Wider format through a 3-stage pipe.
    for (int i = 0; i < 8; i++) send_b(i, i == 0);
    wait_drain();

    // Reset with two sets in flight: both must vanish.
    a_iready = 1'b0;
    send_a(1, 1'b0, 1'b0);
    send_a(3, 1'b0, 1'b0);
    chk("inflight_o_valid", a_ovalid, 1);
    rst = 1'b1;
    q_a.delete();
    @(posedge clk);
    #1;
    chk("flush_o_valid", a_ovalid, 0);
    chk("flush_o_ready", a_oready, 0);
    chk("flush_o_result", a_res, 0);
    chk("flush_o_of", a_of, 0);
    rst      = 1'b0;
    a_iready = 1'b1;
    base     = n_out_a;
    repeat (8) @(posedge clk);
    #1;
    chk("no_stale_output", n_out_a - base, 0);

    send_a(2, 1'b1, 1'b1);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
